// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: sole driver of the register file write port. Merges in-order MEM/WB
// writes with mult/div results, buffering the latter in a small FIFO with kill bits.
module wb_write_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          WbValid,
    input  logic                          WbRegWrite,
    input  logic                          WbMemToReg,
    input  logic [DATA_WIDTH-1:0]         WbAluResult,
    input  logic [DATA_WIDTH-1:0]         WbMemData,
    input  logic [ADDR_WIDTH-1:0]         WbDestReg,
    input  logic                          MdValid,
    output logic                          MdReady,
    input  logic [ADDR_WIDTH-1:0]         MdDestReg,
    input  logic [DATA_WIDTH-1:0]         MdData,
    input  logic [ADDR_WIDTH-1:0]         QueryReg,
    output logic                          QueryHit,
    output logic                          StallReq,
    output logic                          RegWriteSignal,
    output logic [ADDR_WIDTH-1:0]         WriteReg,
    output logic [DATA_WIDTH-1:0]         WriteData,
    output logic [$clog2(FIFO_DEPTH):0]   PendingCount
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PW1   = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_W:0]   DEPTH_C = PW1'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [ADDR_WIDTH-1:0] r_dest [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_vld;
    logic [FIFO_DEPTH-1:0] r_kill;
    logic [PTR_W:0]        r_wptr;
    logic [PTR_W:0]        r_rptr;
    logic [CNT_W-1:0]      r_starve;
    logic                  r_stall;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_wreg;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [PTR_W:0]        w_count;
    logic                  w_empty;
    logic [PTR_W-1:0]      w_head_idx;
    logic [PTR_W-1:0]      w_wr_idx;
    logic                  w_head_kill;
    logic                  w_p;
    logic                  w_a;
    logic                  w_pop;
    logic                  w_head_wr;
    logic                  w_md_drop;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_issue_reg;
    logic [DATA_WIDTH-1:0] w_issue_data;
    logic [FIFO_DEPTH-1:0] w_vld_d;
    logic [FIFO_DEPTH-1:0] w_kill_d;
    logic [CNT_W-1:0]      w_starve_d;
    logic                  w_hit;

    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (r_wptr == r_rptr);
    assign w_head_idx = r_rptr[PTR_W-1:0];
    assign w_wr_idx   = r_wptr[PTR_W-1:0];
    assign w_head_kill = r_kill[w_head_idx];

    // Ready depends only on flops (and reset), never on MdValid.
    assign MdReady = rst_n & (w_count < DEPTH_C);

    always_comb begin
        w_p       = WbValid & WbRegWrite & (WbDestReg != '0);
        w_a       = MdValid & MdReady;
        // A killed head drains regardless of P; it only occupies the slot when P is idle.
        w_pop     = ~w_empty & (w_head_kill | ~w_p);
        w_head_wr = ~w_empty & ~w_head_kill & ~w_p;
        w_md_drop = (MdDestReg == '0) | (w_p & (MdDestReg == WbDestReg));
        w_bypass  = w_a & ~w_md_drop & w_empty & ~w_p;
        w_push    = w_a & ~w_md_drop & ~w_bypass;
    end

    always_comb begin
        w_issue      = 1'b0;
        w_issue_reg  = r_wreg;
        w_issue_data = r_wdata;
        if (w_p) begin
            w_issue      = 1'b1;
            w_issue_reg  = WbDestReg;
            w_issue_data = WbMemToReg ? WbMemData : WbAluResult;
        end else if (w_head_wr) begin
            w_issue      = 1'b1;
            w_issue_reg  = r_dest[w_head_idx];
            w_issue_data = r_data[w_head_idx];
        end else if (w_bypass) begin
            w_issue      = 1'b1;
            w_issue_reg  = MdDestReg;
            w_issue_data = MdData;
        end
    end

    always_comb begin
        w_vld_d  = r_vld;
        w_kill_d = r_kill;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_p && r_vld[i] && (r_dest[i] == WbDestReg)) begin
                w_kill_d[i] = 1'b1;
            end
        end
        if (w_pop) begin
            w_vld_d[w_head_idx]  = 1'b0;
            w_kill_d[w_head_idx] = 1'b0;
        end
        if (w_push) begin
            w_vld_d[w_wr_idx]  = 1'b1;
            w_kill_d[w_wr_idx] = 1'b0;
        end
    end

    always_comb begin
        w_starve_d = r_starve;
        if (w_empty || w_pop) begin
            w_starve_d = '0;
        end else if (r_starve != LIMIT_C) begin
            w_starve_d = r_starve + CNT_W'(1);
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_vld[i] && !r_kill[i] && (r_dest[i] == QueryReg)) begin
                w_hit = 1'b1;
            end
        end
        if (w_a && (MdDestReg == QueryReg)) begin
            w_hit = 1'b1;
        end
    end

    assign QueryHit = w_hit & (QueryReg != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_wreg   <= '0;
            r_wdata  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_vld    <= '0;
            r_kill   <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_we <= w_issue;
            if (w_issue) begin
                r_wreg  <= w_issue_reg;
                r_wdata <= w_issue_data;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW1'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW1'(1);
            end
            r_vld    <= w_vld_d;
            r_kill   <= w_kill_d;
            r_starve <= w_starve_d;
            r_stall  <= (w_starve_d >= LIMIT_C);
        end
    end

    // Payload storage needs no reset; r_vld gates every use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dest[w_wr_idx] <= MdDestReg;
            r_data[w_wr_idx] <= MdData;
        end
    end

    assign RegWriteSignal = r_we;
    assign WriteReg       = r_wreg;
    assign WriteData      = r_wdata;
    assign StallReq       = r_stall;
    assign PendingCount   = w_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected register writes go into a scoreboard queue
// that a negedge monitor drains; side-band outputs are checked inline.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        WbValid, WbRegWrite, WbMemToReg;
    logic [31:0] WbAluResult, WbMemData;
    logic [4:0]  WbDestReg;
    logic        MdValid, MdReady;
    logic [4:0]  MdDestReg;
    logic [31:0] MdData;
    logic [4:0]  QueryReg;
    logic        QueryHit, StallReq, RegWriteSignal;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [1:0]  PendingCount;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    wb_write_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .WbValid        (WbValid),
        .WbRegWrite     (WbRegWrite),
        .WbMemToReg     (WbMemToReg),
        .WbAluResult    (WbAluResult),
        .WbMemData      (WbMemData),
        .WbDestReg      (WbDestReg),
        .MdValid        (MdValid),
        .MdReady        (MdReady),
        .MdDestReg      (MdDestReg),
        .MdData         (MdData),
        .QueryReg       (QueryReg),
        .QueryHit       (QueryHit),
        .StallReq       (StallReq),
        .RegWriteSignal (RegWriteSignal),
        .WriteReg       (WriteReg),
        .WriteData      (WriteData),
        .PendingCount   (PendingCount)
    );

    always #5 clk = ~clk;

    // Every write the DUT presents must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (RegWriteSignal === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got reg=%0d data=%h, required no write",
                         WriteReg, WriteData);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (WriteReg !== e.dst || WriteData !== e.data) begin
                    failures++;
                    $display("FAIL reg_write: got reg=%0d data=%h, required reg=%0d data=%h",
                             WriteReg, WriteData, e.dst, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic v, input logic rw, input logic m2r, input logic [4:0] dst,
                      input logic [31:0] alu, input logic [31:0] mem);
        WbValid     = v;
        WbRegWrite  = rw;
        WbMemToReg  = m2r;
        WbDestReg   = dst;
        WbAluResult = alu;
        WbMemData   = mem;
    endtask

    task automatic md(input logic v, input logic [4:0] dst, input logic [31:0] data);
        MdValid   = v;
        MdDestReg = dst;
        MdData    = data;
    endtask

    task automatic expect_wr(input logic [4:0] dst, input logic [31:0] data);
        exp_t e;
        e.dst  = dst;
        e.data = data;
        sb.push_back(e);
    endtask

    initial begin
        rst_n    = 1'b0;
        QueryReg = '0;
        wb(0, 0, 0, 0, 0, 0);
        md(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", RegWriteSignal, 0);
        chk("reset_wreg", WriteReg, 0);
        chk("reset_wdata", WriteData, 0);
        chk("reset_pending", PendingCount, 0);
        chk("reset_stall", StallReq, 0);
        chk("mdready_in_reset", MdReady, 0);
        rst_n = 1'b1;
        #1;
        chk("mdready_after_reset", MdReady, 1);

        // Primary writes: ALU, dest 0, load, RegWrite=0.
        wb(1, 1, 0, 5, 32'h1234, 32'h9999);
        expect_wr(5, 32'h0000_1234);
        step();
        wb(1, 1, 0, 0, 32'h5555, 0);
        step();
        wb(1, 1, 1, 6, 32'h1111, 32'hCAFE_F00D);
        chk("dest0_no_write", RegWriteSignal, 0);
        expect_wr(6, 32'hCAFE_F00D);
        step();
        wb(1, 0, 0, 8, 32'h2222, 0);
        step();
        chk("regwrite0_no_write", RegWriteSignal, 0);
        chk("wreg_hold", WriteReg, 6);
        chk("wdata_hold", WriteData, 32'hCAFE_F00D);
        wb(0, 0, 0, 0, 0, 0);

        // Bypass of a mult/div result into an empty FIFO.
        md(1, 7, 32'hDEAD_BEEF);
        QueryReg = 7;
        #1;
        chk("bypass_mdready", MdReady, 1);
        chk("query_accept", QueryHit, 1);
        expect_wr(7, 32'hDEAD_BEEF);
        step();
        md(0, 0, 0);
        QueryReg = 0;
        #1;
        chk("bypass_pending", PendingCount, 0);
        step();

        // Mult/div result to r0 is swallowed.
        md(1, 0, 32'h0000_0BAD);
        #1;
        chk("md_r0_ready", MdReady, 1);
        step();
        md(0, 0, 0);
        #1;
        chk("md_r0_pending", PendingCount, 0);
        step();
        chk("md_r0_no_write", RegWriteSignal, 0);

        // Starvation: P every cycle while two results queue up.
        wb(1, 1, 0, 10, 32'hA0, 0);
        md(1, 3, 32'h33);
        #1;
        chk("starve_ready0", MdReady, 1);
        expect_wr(10, 32'hA0);
        step();
        md(1, 4, 32'h44);
        #1;
        chk("starve_pending1", PendingCount, 1);
        chk("starve_ready1", MdReady, 1);
        expect_wr(10, 32'hA0);
        step();
        md(0, 0, 0);
        QueryReg = 4;
        #1;
        chk("starve_pending2", PendingCount, 2);
        chk("starve_full_ready", MdReady, 0);
        chk("query_fifo", QueryHit, 1);
        QueryReg = 0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_early", StallReq, 0);
            expect_wr(10, 32'hA0);
            step();
        end
        chk("stall_rise", StallReq, 1);
        wb(0, 0, 0, 0, 0, 0);
        expect_wr(3, 32'h33);
        step();
        chk("stall_clear", StallReq, 0);
        chk("drain_pending1", PendingCount, 1);
        expect_wr(4, 32'h44);
        step();
        chk("drain_pending0", PendingCount, 0);
        step();

        // Kill of a buffered entry by a younger primary write.
        wb(1, 1, 0, 12, 32'hB0, 0);
        md(1, 9, 32'h11);
        expect_wr(12, 32'hB0);
        step();
        wb(1, 1, 0, 9, 32'h22, 0);
        md(0, 0, 0);
        QueryReg = 9;
        #1;
        chk("query_prekill", QueryHit, 1);
        expect_wr(9, 32'h22);
        step();
        wb(0, 0, 0, 0, 0, 0);
        #1;
        chk("query_killed", QueryHit, 0);
        chk("killed_pending", PendingCount, 1);
        step();
        chk("killed_popped", PendingCount, 0);
        chk("killed_no_write", RegWriteSignal, 0);
        QueryReg = 0;

        // Same-cycle accept to the primary's destination is dropped.
        wb(1, 1, 0, 13, 32'h77, 0);
        md(1, 13, 32'h88);
        #1;
        chk("samecycle_ready", MdReady, 1);
        expect_wr(13, 32'h77);
        step();
        wb(0, 0, 0, 0, 0, 0);
        md(0, 0, 0);
        #1;
        chk("samecycle_pending", PendingCount, 0);
        step();
        chk("samecycle_no_write", RegWriteSignal, 0);

        // Full FIFO popping while a new offer waits.
        wb(1, 1, 0, 14, 32'hE0, 0);
        md(1, 20, 32'h200);
        expect_wr(14, 32'hE0);
        step();
        md(1, 21, 32'h201);
        expect_wr(14, 32'hE0);
        step();
        wb(0, 0, 0, 0, 0, 0);
        md(1, 22, 32'h202);
        #1;
        chk("full_pop_ready", MdReady, 0);
        chk("full_pending", PendingCount, 2);
        expect_wr(20, 32'h200);
        step();
        chk("after_pop_ready", MdReady, 1);
        chk("after_pop_pending", PendingCount, 1);
        expect_wr(21, 32'h201);
        step();
        md(0, 0, 0);
        #1;
        chk("late_accept_pending", PendingCount, 1);
        expect_wr(22, 32'h202);
        step();
        chk("full_drain_pending", PendingCount, 0);
        step();

        // Reset with two entries pending discards them.
        wb(1, 1, 0, 15, 32'hF0, 0);
        md(1, 23, 32'h230);
        expect_wr(15, 32'hF0);
        step();
        wb(1, 1, 0, 15, 32'hF1, 0);
        md(1, 24, 32'h240);
        expect_wr(15, 32'hF1);
        step();
        wb(0, 0, 0, 0, 0, 0);
        md(0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("prereset_pending", PendingCount, 2);
        chk("midreset_ready", MdReady, 0);
        step();
        chk("rst2_we", RegWriteSignal, 0);
        chk("rst2_wreg", WriteReg, 0);
        chk("rst2_wdata", WriteData, 0);
        chk("rst2_pending", PendingCount, 0);
        chk("rst2_stall", StallReq, 0);
        rst_n = 1'b1;
        repeat (4) step();
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-stage block directly upstream of the register file; sole driver of its write port (RegWriteSignal, WriteReg, WriteData).
- Merges the in-order MEM/WB result (ALU or load) with results from the long-latency mult/div unit, which returns over a valid/ready handshake.
- Mult/div results that cannot issue immediately wait in a small FIFO.
- Also provides a pending-write query for decode-stage hazard stalls and a stall request against starvation.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register index width
FIFO_DEPTH, 2, mult/div result buffer entries (power of 2, >=2)
STARVE_LIMIT, 4, cycles a buffered head may wait before StallReq asserts

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
WbValid  in  1  MEM/WB stage holds a valid instruction
WbRegWrite  in  1  instruction writes a GPR
WbMemToReg  in  1  1 = write WbMemData, 0 = write WbAluResult
WbAluResult  in  DATA_WIDTH  ALU result
WbMemData  in  DATA_WIDTH  load data
WbDestReg  in  ADDR_WIDTH  destination register
MdValid  in  1  mult/div result offered
MdReady  out  1  block accepts mult/div result
MdDestReg  in  ADDR_WIDTH  mult/div destination
MdData  in  DATA_WIDTH  mult/div result
QueryReg  in  ADDR_WIDTH  decode-stage source register to check
QueryHit  out  1  a write to QueryReg is pending in this block
StallReq  out  1  upstream must insert a bubble (WbValid=0) next cycle
RegWriteSignal  out  1  register file write enable (registered)
WriteReg  out  ADDR_WIDTH  register file write index (registered)
WriteData  out  DATA_WIDTH  register file write data (registered)
PendingCount  out  clog2(FIFO_DEPTH)+1  live FIFO entries

Behaviour:
- Reset (rst_n=0 at posedge): RegWriteSignal=0, WriteReg=0, WriteData=0, FIFO empty, all kill bits clear, starve counter=0, StallReq=0. MdReady=0 while rst_n=0; MdReady=1 from the first cycle after reset. Reset mid-operation discards buffered results silently.
- Primary request P = WbValid & WbRegWrite & (WbDestReg!=0). Md accept A = MdValid & MdReady.
- MdReady = (PendingCount < FIFO_DEPTH), derived from registered state only. There is no combinational path from MdValid. A full FIFO popping this cycle still shows MdReady=0.
- Issue priority per cycle: (1) P; (2) FIFO head, if the FIFO is non-empty; (3) A, bypassing the FIFO, if the FIFO is empty and P=0. The winner is registered onto RegWriteSignal/WriteReg/WriteData at the next posedge (latency 1). If nothing issues, RegWriteSignal=0 and WriteReg/WriteData hold their previous values.
- Accepted Md that does not issue via bypass is pushed. Push and pop in the same cycle are legal; count is unchanged.
- Md result with MdDestReg==0: the handshake completes, but the result is discarded and not pushed.
- Ordering: Md results are always older than any concurrent or later primary write. When P issues to register X:
  - every FIFO entry with dest X gets its kill bit set;
  - a same-cycle A with MdDestReg==X is accepted and discarded.
- A killed entry at the head pops without writing. That pop consumes the issue slot only when P=0, and produces no RegWriteSignal.
- Starve counter: increments each cycle the FIFO is non-empty and the head does not pop; clears on pop or when the FIFO becomes empty; saturates.
- StallReq: registered; 1 when counter >= STARVE_LIMIT. Deasserts the cycle after the head pops.
- QueryHit: combinational. 1 iff QueryReg!=0 and (a live, unkilled FIFO entry has dest==QueryReg, or A=1 with MdDestReg==QueryReg).
- PendingCount counts entries including killed ones.
- FIFO pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses an extra pointer bit.

Test Plan:
- Reset, then P: WbDestReg=5, WbMemToReg=0, WbAluResult=0x1234 -> next cycle RegWriteSignal=1, WriteReg=5, WriteData=0x00001234; WbDestReg=0 -> RegWriteSignal stays 0.
- FIFO empty, P=0, MdValid=1 with reg 7, data 0xDEADBEEF -> MdReady=1, write of reg 7 = 0xDEADBEEF one cycle later, PendingCount stays 0.
- P held every cycle while Md sends reg 3 then reg 4 -> PendingCount reaches 2, MdReady=0. StallReq rises 4 cycles after the first push. After WbValid drops, reg 3 then reg 4 are written on consecutive cycles and StallReq clears.
- FIFO holds reg 9 (data 0x11); P writes reg 9 with 0x22 -> reg 9 = 0x22 written; the buffered entry later pops with no RegWriteSignal; QueryReg=9 gives QueryHit=0 after the kill.
- Full FIFO with the head popping the same cycle MdValid=1 -> MdReady=0 that cycle and the offer is accepted the next cycle. Assert rst_n=0 with 2 entries pending -> outputs 0 and PendingCount=0 after the posedge, and the buffered entries are never written.
